// File: rtl/mem_port_arbiter.sv
// Arbitrates instruction fetch (IF) and data access (MA) onto one shared memory port.
// Define MEM_ARB_TIMEOUT_EN to add a busy-cycle watchdog that aborts a stuck access.
module mem_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned TIMEOUT      = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ack,
    input  logic        ma_req,
    input  logic        ma_we,
    input  logic [31:0] ma_addr,
    input  logic [31:0] ma_wdata,
    output logic [31:0] ma_rdata,
    output logic        ma_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready,
    output logic        stall_if,
    output logic        stall_ma,
    output logic        err
);

    localparam int unsigned SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [SW-1:0] SLim = SW'(STARVE_LIMIT);

    typedef enum logic [1:0] {StIdle, StBusyIf, StBusyMa} state_e;

    state_e      state_q, state_d;
    logic [SW-1:0] starve_q, starve_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        busy, done, timeout, grant_if, grant_ma;

    // Outputs are gated by reset so nothing leaks out while a reset is being applied.
    assign busy     = (state_q != StIdle) && !reset;
    assign done     = busy && (mem_ready || timeout);
    assign grant_if = if_req && (!ma_req || (starve_q == SLim));
    assign grant_ma = ma_req && !grant_if;

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int unsigned WW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WW-1:0] WdLast = WW'(TIMEOUT - 1);

    logic [WW-1:0] wd_q, wd_d;

    assign timeout = busy && !mem_ready && (wd_q == WdLast);
    assign wd_d    = (busy && !done) ? wd_q + 1'b1 : '0;

    always_ff @(posedge clk) begin
        if (reset) wd_q <= '0;
        else       wd_q <= wd_d;
    end
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timeout        = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            starve_q <= '0;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            starve_q <= starve_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        starve_d = starve_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = we_q;
        unique case (state_q)
            StIdle: begin
                if (grant_if) begin
                    state_d  = StBusyIf;
                    addr_d   = if_addr;
                    wdata_d  = '0;
                    we_d     = 1'b0;
                    starve_d = '0;
                end else if (grant_ma) begin
                    state_d = StBusyMa;
                    addr_d  = ma_addr;
                    wdata_d = ma_wdata;
                    we_d    = ma_we;
                    if (if_req && (starve_q != SLim)) starve_d = starve_q + 1'b1;
                end
            end
            StBusyIf, StBusyMa: begin
                if (done) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign mem_req   = busy;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign mem_we    = we_q;

    assign if_ack   = done && (state_q == StBusyIf);
    assign ma_ack   = done && (state_q == StBusyMa);
    // A watchdog abort returns zero data, so rdata follows mem_ready rather than ack.
    assign if_rdata = (if_ack && mem_ready) ? mem_rdata : '0;
    assign ma_rdata = (ma_ack && mem_ready) ? mem_rdata : '0;
    assign err      = timeout;

    assign stall_if = if_req & ~if_ack;
    assign stall_ma = ma_req & ~ma_ack;

endmodule
